ab_operand_feeder: RTL and testbench

//  Upstream operand source for the kadai4 multiply stage.
//  A host-side write port pushes (A,B) operand pairs into an internal FIFO.
//  The block answers the consumer's REQ_AB level request: it pops one pair,

---
 rtl/ab_operand_feeder_pkg.sv | 23 ++
 rtl/ab_operand_feeder_if.sv | 29 ++
 rtl/ab_operand_feeder_pair_fifo.sv | 76 +++++++
 rtl/ab_operand_feeder.sv | 109 ++++++++++
 tb/tb_ab_operand_feeder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ab_operand_feeder_pkg.sv
// Shared types and constants for the A/B operand feeder: FSM encoding,
// default sizes and the optional operand LFSR seed/taps.
package ab_feeder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   localparam int DEF_DW    = 8;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_AW    = 3;

   // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ab_operand_feeder_if.sv
// Host write port plus consumer request/ack port of the operand feeder.
// master = host/consumer side, slave = feeder.
interface ab_feeder_if #(
   parameter int DW = 8,
   parameter int AW = 3
);
   logic          WR_EN;
   logic [DW-1:0] WR_A;
   logic [DW-1:0] WR_B;
   logic          FULL;
   logic          EMPTY;
   logic [AW:0]   COUNT;
   logic          OVERFLOW;
   logic          REQ_AB;
   logic          ACK;
   logic [DW-1:0] A;
   logic [DW-1:0] B;
   logic [15:0]   ISSUED;

   modport master (
      output WR_EN, WR_A, WR_B, REQ_AB,
      input  FULL, EMPTY, COUNT, OVERFLOW, ACK, A, B, ISSUED
   );

   modport slave (
      input  WR_EN, WR_A, WR_B, REQ_AB,
      output FULL, EMPTY, COUNT, OVERFLOW, ACK, A, B, ISSUED
   );
endinterface

// File: rtl/ab_operand_feeder_pair_fifo.sv
// Synchronous FIFO of operand pairs with explicit occupancy count and a
// sticky overflow flag; a push while full is dropped even if a pop coincides.
module ab_pair_fifo
   import ab_feeder_pkg::*;
#(
   parameter int W     = 2 * DEF_DW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          push_ok, pop_ok;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign overflow = ovf_q;
   assign dout     = mem_q[rd_ptr_q];

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (push && full);
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok)
         rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: rtl/ab_operand_feeder.sv
// Operand feeder: pops an (A,B) pair per consumer request and pulses ACK.
// Define OPERAND_LFSR_EN to serve pseudo-random operands when the FIFO is empty.
module ab_operand_feeder
   import ab_feeder_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic      CLK,
   input  logic      RST,
   ab_feeder_if.slave bus
);

   state_e          state_q, state_d;
   logic [DW-1:0]   a_q, a_d, b_q, b_d;
   logic            ack_q, ack_d;
   logic [15:0]     issued_q, issued_d;
   logic            pop;
   logic [2*DW-1:0] head;
   logic            fifo_full, fifo_empty, fifo_ovf;
   logic [AW:0]     fifo_count;
`ifdef OPERAND_LFSR_EN
   logic [15:0]     lfsr_q, lfsr_d;
`endif

   ab_pair_fifo #(.W(2*DW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .push     (bus.WR_EN),
      .din      ({bus.WR_A, bus.WR_B}),
      .pop      (pop),
      .dout     (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .overflow (fifo_ovf)
   );

   assign bus.FULL     = fifo_full;
   assign bus.EMPTY    = fifo_empty;
   assign bus.COUNT    = fifo_count;
   assign bus.OVERFLOW = fifo_ovf;
   assign bus.ACK      = ack_q;
   assign bus.A        = a_q;
   assign bus.B        = b_q;
   assign bus.ISSUED   = issued_q;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      ack_d    = 1'b0;
      issued_d = issued_q;
      pop      = 1'b0;
`ifdef OPERAND_LFSR_EN
      lfsr_d   = lfsr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.REQ_AB && !fifo_empty) begin
               pop        = 1'b1;
               {a_d, b_d} = head;
               ack_d      = 1'b1;
               state_d    = S_ACK;
            end
`ifdef OPERAND_LFSR_EN
            else if (bus.REQ_AB) begin
               a_d     = DW'(lfsr_q[15:8]);
               b_d     = DW'(lfsr_q[7:0]);
               ack_d   = 1'b1;
               lfsr_d  = lfsr_step(lfsr_q);
               state_d = S_ACK;
            end
`endif
         end
         S_ACK: begin
            issued_d = issued_q + 16'd1;
            state_d  = S_GAP;
         end
         // Gap gives the consumer a cycle to drop its level request.
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ack_q    <= 1'b0;
         issued_q <= '0;
`ifdef OPERAND_LFSR_EN
         lfsr_q   <= LFSR_SEED;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ack_q    <= ack_d;
         issued_q <= issued_d;
`ifdef OPERAND_LFSR_EN
         lfsr_q   <= lfsr_d;
`endif
      end
   end

endmodule

// File: tb/tb_ab_operand_feeder.sv
// Directed bench for ab_operand_feeder: reset, single issue, full/overflow
// and drain order, empty request, reset abort, push+pop, optional LFSR.
module tb_ab_operand_feeder;

   logic CLK = 1'b0;
   logic RST;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always #5 CLK = ~CLK;

   ab_feeder_if #(.DW(8), .AW(3)) bus ();

   ab_operand_feeder #(.DW(8), .DEPTH(8), .AW(3)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      bus.WR_EN = 1'b1;
      bus.WR_A  = a;
      bus.WR_B  = b;
      tick();
      bus.WR_EN = 1'b0;
   endtask

   task automatic wait_ack(input string tag, input int max);
      int n;
      n = 0;
      while (bus.ACK !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      check(tag, {31'd0, bus.ACK}, 32'd1);
   endtask

   initial begin
      int last_ack;
      int ack_seen;
      RST        = 1'b1;
      bus.WR_EN  = 1'b0;
      bus.WR_A   = '0;
      bus.WR_B   = '0;
      bus.REQ_AB = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      tick();

      // 1: reset state
      check("rst_ack",    {31'd0, bus.ACK},      32'd0);
      check("rst_a",      {24'd0, bus.A},        32'd0);
      check("rst_b",      {24'd0, bus.B},        32'd0);
      check("rst_empty",  {31'd0, bus.EMPTY},    32'd1);
      check("rst_full",   {31'd0, bus.FULL},     32'd0);
      check("rst_count",  {28'd0, bus.COUNT},    32'd0);
      check("rst_ovf",    {31'd0, bus.OVERFLOW}, 32'd0);
      check("rst_issued", {16'd0, bus.ISSUED},   32'd0);

      // 2: single pair
      push(8'h4a, 8'h5b);
      check("t2_count", {28'd0, bus.COUNT}, 32'd1);
      bus.REQ_AB = 1'b1;
      tick();
      check("t2_ack",   {31'd0, bus.ACK},   32'd1);
      check("t2_a",     {24'd0, bus.A},     32'h4a);
      check("t2_b",     {24'd0, bus.B},     32'h5b);
      check("t2_empty", {31'd0, bus.EMPTY}, 32'd1);
      bus.REQ_AB = 1'b0;
      tick();
      check("t2_ack_drop", {31'd0, bus.ACK},    32'd0);
      check("t2_issued",   {16'd0, bus.ISSUED}, 32'd1);
      check("t2_a_hold",   {24'd0, bus.A},      32'h4a);
      tick();

      // 3: fill, overflow, ordered drain
      for (int i = 0; i < 8; i++) push(8'(2*i+1), 8'(2*i+2));
      check("t3_full_at8", {31'd0, bus.FULL},     32'd1);
      check("t3_ovf_pre",  {31'd0, bus.OVERFLOW}, 32'd0);
      push(8'h11, 8'h12);
      check("t3_full",  {31'd0, bus.FULL},     32'd1);
      check("t3_ovf",   {31'd0, bus.OVERFLOW}, 32'd1);
      check("t3_count", {28'd0, bus.COUNT},    32'd8);
      bus.REQ_AB = 1'b1;
      last_ack   = 0;
      for (int k = 0; k < 8; k++) begin
         wait_ack($sformatf("t3_ack%0d", k), 6);
         check($sformatf("t3_a%0d", k), {24'd0, bus.A}, 32'(2*k+1));
         check($sformatf("t3_b%0d", k), {24'd0, bus.B}, 32'(2*k+2));
         if (k > 0) check($sformatf("t3_gap%0d", k), 32'(cyc - last_ack), 32'd3);
         last_ack = cyc;
         if (k == 7) bus.REQ_AB = 1'b0;
         tick();
      end
      check("t3_empty",  {31'd0, bus.EMPTY},    32'd1);
      check("t3_issued", {16'd0, bus.ISSUED},   32'd9);
      check("t3_sticky", {31'd0, bus.OVERFLOW}, 32'd1);
      ack_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.ACK === 1'b1) ack_seen++;
      end
      check("t3_no9th", 32'(ack_seen), 32'd0);

`ifndef OPERAND_LFSR_EN
      // 4: request with empty FIFO, then a late push
      bus.REQ_AB = 1'b1;
      ack_seen   = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.ACK === 1'b1) ack_seen++;
      end
      check("t4_no_ack", 32'(ack_seen), 32'd0);
      push(8'h11, 8'h22);
      check("t4_ack_early", {31'd0, bus.ACK}, 32'd0);
      tick();
      check("t4_ack", {31'd0, bus.ACK}, 32'd1);
      check("t4_a",   {24'd0, bus.A},   32'h11);
      check("t4_b",   {24'd0, bus.B},   32'h22);
      bus.REQ_AB = 1'b0;
      tick();
      tick();
`endif

      // 5: reset while in S_ACK with 3 entries queued
      for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 8'h40 + 8'(i));
      bus.REQ_AB = 1'b1;
      tick();
      check("t5_ack",   {31'd0, bus.ACK},   32'd1);
      check("t5_count", {28'd0, bus.COUNT}, 32'd3);
      RST        = 1'b1;
      bus.REQ_AB = 1'b0;
      tick();
      check("t5_ack_rst", {31'd0, bus.ACK},      32'd0);
      check("t5_count0",  {28'd0, bus.COUNT},    32'd0);
      check("t5_a0",      {24'd0, bus.A},        32'd0);
      check("t5_b0",      {24'd0, bus.B},        32'd0);
      check("t5_empty",   {31'd0, bus.EMPTY},    32'd1);
      check("t5_ovf0",    {31'd0, bus.OVERFLOW}, 32'd0);
      check("t5_issued0", {16'd0, bus.ISSUED},   32'd0);
      RST = 1'b0;
      tick();

      // simultaneous push and pop keeps the count
      push(8'haa, 8'hbb);
      bus.WR_EN  = 1'b1;
      bus.WR_A   = 8'hcc;
      bus.WR_B   = 8'hdd;
      bus.REQ_AB = 1'b1;
      tick();
      bus.WR_EN  = 1'b0;
      bus.REQ_AB = 1'b0;
      check("pp_count", {28'd0, bus.COUNT}, 32'd1);
      check("pp_a",     {24'd0, bus.A},     32'haa);
      check("pp_b",     {24'd0, bus.B},     32'hbb);
      tick();
      tick();
      bus.REQ_AB = 1'b1;
      tick();
      bus.REQ_AB = 1'b0;
      check("pp_ack2", {31'd0, bus.ACK}, 32'd1);
      check("pp_a2",   {24'd0, bus.A},   32'hcc);
      check("pp_b2",   {24'd0, bus.B},   32'hdd);
      tick();
      tick();

`ifdef OPERAND_LFSR_EN
      // 6: LFSR operands after reset with an empty FIFO
      RST = 1'b1;
      tick();
      RST        = 1'b0;
      bus.REQ_AB = 1'b1;
      tick();
      bus.REQ_AB = 1'b0;
      check("t6_ack", {31'd0, bus.ACK}, 32'd1);
      check("t6_a",   {24'd0, bus.A},   32'hac);
      check("t6_b",   {24'd0, bus.B},   32'he1);
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
